// File: rtl/saxil_read_regs.sv
// AXI4-Lite read-only slave over a flat bank of external registers.
// It uses a one-entry address skid buffer, returns SLVERR for bad accesses and pulses a strobe for clear-on-read.
module saxil_read_regs #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned SECURE_ONLY = 0,
  localparam int unsigned IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                         saxil_read_regs_clk,
  input  logic                         saxil_read_regs_rst,
  input  logic                         saxil_read_arvalid,
  output logic                         saxil_read_arready,
  input  logic [ADDR_W-1:0]            saxil_read_araddr,
  input  logic [2:0]                   saxil_read_arprot,
  output logic                         saxil_read_rvalid,
  input  logic                         saxil_read_rready,
  output logic [DATA_W-1:0]            saxil_read_rdata,
  output logic [1:0]                   saxil_read_rresp,
  input  logic [NUM_REGS*DATA_W-1:0]   saxil_read_regs_reg_data,
  output logic                         saxil_read_regs_rd_stb,
  output logic [IDX_W-1:0]             saxil_read_regs_rd_idx
);

  localparam int unsigned BYTES    = DATA_W / 8;
  localparam int unsigned ADDR_LSB = $clog2(BYTES);
  localparam int unsigned WORD_W   = ADDR_W - ADDR_LSB;
  localparam logic [WORD_W-1:0] REG_LIMIT = WORD_W'(NUM_REGS);

  logic                skid_valid, skid_valid_next;
  logic [ADDR_W-1:0]   skid_addr, skid_addr_next;
  logic [2:0]          skid_prot, skid_prot_next;
  logic                ar_hs, r_free, load_r;
  logic [ADDR_W-1:0]   sel_addr;
  logic [2:0]          sel_prot;
  logic [WORD_W-1:0]   sel_word;
  logic [IDX_W-1:0]    sel_idx;
  logic                sel_err;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic                unused_ok;

  always_comb begin
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      regs[k] = saxil_read_regs_reg_data[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    ar_hs           = saxil_read_arvalid && saxil_read_arready;
    r_free          = !saxil_read_rvalid || saxil_read_rready;
    load_r          = 1'b0;
    sel_addr        = saxil_read_araddr;
    sel_prot        = saxil_read_arprot;
    skid_valid_next = skid_valid;
    skid_addr_next  = skid_addr;
    skid_prot_next  = skid_prot;
    // A parked request always drains before a newly arriving one to keep order.
    if (skid_valid && r_free) begin
      load_r          = 1'b1;
      sel_addr        = skid_addr;
      sel_prot        = skid_prot;
      skid_valid_next = ar_hs;
      if (ar_hs) begin
        skid_addr_next = saxil_read_araddr;
        skid_prot_next = saxil_read_arprot;
      end
    end else if (ar_hs && r_free) begin
      load_r = 1'b1;
    end else if (ar_hs) begin
      skid_valid_next = 1'b1;
      skid_addr_next  = saxil_read_araddr;
      skid_prot_next  = saxil_read_arprot;
    end
  end

  always_comb begin
    sel_word = sel_addr[ADDR_W-1:ADDR_LSB];
    sel_idx  = sel_addr[ADDR_LSB +: IDX_W];
    sel_err  = (sel_word >= REG_LIMIT) || ((SECURE_ONLY != 0) && sel_prot[1]);
  end

  assign unused_ok = ^{sel_addr[ADDR_LSB-1:0], sel_prot[2], sel_prot[0]};

  always_ff @(posedge saxil_read_regs_clk) begin
    if (saxil_read_regs_rst) begin
      saxil_read_arready     <= 1'b0;
      saxil_read_rvalid      <= 1'b0;
      saxil_read_rdata       <= '0;
      saxil_read_rresp       <= 2'b00;
      saxil_read_regs_rd_stb <= 1'b0;
      saxil_read_regs_rd_idx <= '0;
      skid_valid             <= 1'b0;
      skid_addr              <= '0;
      skid_prot              <= '0;
    end else begin
      saxil_read_arready     <= !skid_valid_next;
      skid_valid             <= skid_valid_next;
      skid_addr              <= skid_addr_next;
      skid_prot              <= skid_prot_next;
      saxil_read_regs_rd_stb <= load_r && !sel_err;
      if (load_r) begin
        saxil_read_rvalid <= 1'b1;
        if (sel_err) begin
          saxil_read_rdata <= '0;
          saxil_read_rresp <= 2'b10;
        end else begin
          saxil_read_rdata       <= regs[sel_idx];
          saxil_read_rresp       <= 2'b00;
          saxil_read_regs_rd_idx <= sel_idx;
        end
      end else if (saxil_read_rvalid && saxil_read_rready) begin
        saxil_read_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_saxil_read_regs.sv
// Bench for saxil_read_regs: a 32-bit secure-only instance and a 64-bit 12-register instance share one AR/R stimulus.
// A request-queue reference model predicts every cycle.
module tb_saxil_read_regs;

  logic        clk;
  logic        rst;
  logic        arvalid;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rready;

  logic        a_arready, a_rvalid, a_rd_stb;
  logic [31:0] a_rdata;
  logic [1:0]  a_rresp;
  logic [3:0]  a_rd_idx;
  logic        b_arready, b_rvalid, b_rd_stb;
  logic [63:0] b_rdata;
  logic [1:0]  b_rresp;
  logic [3:0]  b_rd_idx;

  logic [31:0]    regs32 [16];
  logic [63:0]    regs64 [12];
  logic [16*32-1:0] a_flat;
  logic [12*64-1:0] b_flat;

  always_comb begin
    for (int k = 0; k < 16; k++) a_flat[k*32 +: 32] = regs32[k];
    for (int k = 0; k < 12; k++) b_flat[k*64 +: 64] = regs64[k];
  end

  saxil_read_regs #(.DATA_W(32), .ADDR_W(32), .NUM_REGS(16), .SECURE_ONLY(1)) dut_a (
    .saxil_read_regs_clk(clk), .saxil_read_regs_rst(rst),
    .saxil_read_arvalid(arvalid), .saxil_read_arready(a_arready),
    .saxil_read_araddr(araddr), .saxil_read_arprot(arprot),
    .saxil_read_rvalid(a_rvalid), .saxil_read_rready(rready),
    .saxil_read_rdata(a_rdata), .saxil_read_rresp(a_rresp),
    .saxil_read_regs_reg_data(a_flat),
    .saxil_read_regs_rd_stb(a_rd_stb), .saxil_read_regs_rd_idx(a_rd_idx)
  );

  saxil_read_regs #(.DATA_W(64), .ADDR_W(32), .NUM_REGS(12), .SECURE_ONLY(0)) dut_b (
    .saxil_read_regs_clk(clk), .saxil_read_regs_rst(rst),
    .saxil_read_arvalid(arvalid), .saxil_read_arready(b_arready),
    .saxil_read_araddr(araddr), .saxil_read_arprot(arprot),
    .saxil_read_rvalid(b_rvalid), .saxil_read_rready(rready),
    .saxil_read_rdata(b_rdata), .saxil_read_rresp(b_rresp),
    .saxil_read_regs_reg_data(b_flat),
    .saxil_read_regs_rd_stb(b_rd_stb), .saxil_read_regs_rd_idx(b_rd_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: accepted requests wait in a queue until the single response slot is free.
  typedef struct packed {
    logic [2:0]  prot;
    logic [31:0] addr;
  } req_t;

  req_t        pend [$];
  logic        m_rvalid = 1'b0, m_arready = 1'b0, m_hs = 1'b0;
  logic [31:0] ea_data = '0;
  logic [63:0] eb_data = '0;
  logic [1:0]  ea_resp = '0, eb_resp = '0;
  logic        ea_stb = 1'b0, eb_stb = 1'b0;
  logic [3:0]  ea_idx = '0, eb_idx = '0;
  logic        started = 1'b0;

  task automatic predict(input req_t q);
    int unsigned wa, wb;
    wa = q.addr / 4;
    wb = q.addr / 8;
    if (wa >= 16 || q.prot[1]) begin
      ea_data = '0; ea_resp = 2'b10;
    end else begin
      ea_data = regs32[wa]; ea_resp = 2'b00; ea_stb = 1'b1; ea_idx = 4'(wa);
    end
    if (wb >= 12) begin
      eb_data = '0; eb_resp = 2'b10;
    end else begin
      eb_data = regs64[wb]; eb_resp = 2'b00; eb_stb = 1'b1; eb_idx = 4'(wb);
    end
  endtask

  task automatic model_step();
    req_t q;
    if (rst) begin
      pend.delete();
      m_rvalid = 1'b0; m_arready = 1'b0; m_hs = 1'b0;
      ea_stb = 1'b0; eb_stb = 1'b0;
    end else begin
      m_hs = arvalid && m_arready;
      ea_stb = 1'b0; eb_stb = 1'b0;
      if (m_rvalid && rready) m_rvalid = 1'b0;
      if (m_hs) begin
        q.addr = araddr; q.prot = arprot;
        pend.push_back(q);
      end
      if (!m_rvalid && pend.size() != 0) begin
        q = pend.pop_front();
        m_rvalid = 1'b1;
        predict(q);
      end
      m_arready = (pend.size() == 0);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      check_eq("a_arready", a_arready, m_arready);
      check_eq("b_arready", b_arready, m_arready);
      check_eq("a_rvalid", a_rvalid, m_rvalid);
      check_eq("b_rvalid", b_rvalid, m_rvalid);
      check_eq("a_rd_stb", a_rd_stb, ea_stb);
      check_eq("b_rd_stb", b_rd_stb, eb_stb);
      if (m_rvalid) begin
        check_eq("a_rdata", a_rdata, ea_data);
        check_eq("a_rresp", a_rresp, ea_resp);
        check_eq("b_rdata", b_rdata, eb_data);
        check_eq("b_rresp", b_rresp, eb_resp);
      end
      if (ea_stb) check_eq("a_rd_idx", a_rd_idx, ea_idx);
      if (eb_stb) check_eq("b_rd_idx", b_rd_idx, eb_idx);
    end
  end

  task automatic issue(input logic [31:0] addr, input logic [2:0] prot);
    bit got;
    got = 1'b0;
    arvalid = 1'b1; araddr = addr; arprot = prot;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      got = m_hs;
    end
    if (!got) check_eq("ar_handshake_timeout", got, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_a_rdata"}, a_rdata, 0);
    check_eq({tag, "_a_rresp"}, a_rresp, 0);
    check_eq({tag, "_a_rd_idx"}, a_rd_idx, 0);
    check_eq({tag, "_b_rdata"}, b_rdata, 0);
    check_eq({tag, "_b_rd_idx"}, b_rd_idx, 0);
    check_eq({tag, "_a_rvalid"}, a_rvalid, 0);
    check_eq({tag, "_a_arready"}, a_arready, 0);
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return $urandom | 32'h8000_0000;
    return 32'($urandom_range(0, 32'h7F));
  endfunction

  initial begin
    rst = 1'b1; arvalid = 1'b0; araddr = '0; arprot = '0; rready = 1'b1;
    for (int k = 0; k < 16; k++) regs32[k] = 32'hA500_0000 + 32'(k);
    for (int k = 0; k < 12; k++) regs64[k] = 64'hB600_0000_0000_0000 + 64'(k);
    @(posedge clk); #1;
    started = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single in-range read
    issue(32'h8, 3'b000); arvalid = 1'b0;
    @(negedge clk);
    check_eq("single_rdata", a_rdata, 32'hA500_0002);
    check_eq("single_rresp", a_rresp, 2'b00);
    check_eq("single_stb", a_rd_stb, 1);
    check_eq("single_idx", a_rd_idx, 2);

    // Out-of-range for the 16-register bank
    @(posedge clk); #1;
    issue(32'h40, 3'b000); arvalid = 1'b0;
    @(negedge clk);
    check_eq("oor_rresp", a_rresp, 2'b10);
    check_eq("oor_rdata", a_rdata, 0);
    check_eq("oor_stb", a_rd_stb, 0);

    // Non-secure access rejected only by the secure-only instance
    @(posedge clk); #1;
    issue(32'h0, 3'b010); arvalid = 1'b0;
    @(negedge clk);
    check_eq("nsec_rresp", a_rresp, 2'b10);
    check_eq("nsec_rdata", a_rdata, 0);
    check_eq("nsec_b_rresp", b_rresp, 2'b00);
    @(posedge clk); #1;
    issue(32'h0, 3'b000); arvalid = 1'b0;
    @(negedge clk);
    check_eq("sec_rresp", a_rresp, 2'b00);
    check_eq("sec_rdata", a_rdata, 32'hA500_0000);

    // 64-bit decode uses address bit 3 upward
    @(posedge clk); #1;
    issue(32'h18, 3'b000); arvalid = 1'b0;
    @(negedge clk);
    check_eq("w64_rdata", b_rdata, 64'hB600_0000_0000_0003);
    check_eq("w64_idx", b_rd_idx, 3);

    // Back-to-back at full throughput
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      issue(32'(i * 4), 3'b000);
      @(negedge clk);
      check_eq("b2b_rdata", a_rdata, 32'hA500_0000 + 32'(i));
      check_eq("b2b_arready", a_arready, 1);
    end
    arvalid = 1'b0;

    // Backpressure: two accepted, third waits while R holds its data
    @(posedge clk); #1;
    rready = 1'b0;
    issue(32'h4, 3'b000);
    issue(32'h8, 3'b000);
    araddr = 32'hC;
    repeat (3) begin
      @(negedge clk);
      check_eq("bp_arready", a_arready, 0);
      check_eq("bp_hold", a_rdata, 32'hA500_0001);
    end
    @(posedge clk); #1;
    rready = 1'b1;
    issue(32'hC, 3'b000); arvalid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Reset with R and skid both occupied
    rready = 1'b0;
    issue(32'h18, 3'b000);
    issue(32'h1C, 3'b000);
    arvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rready = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    repeat (4) begin
      @(negedge clk);
      check_eq("midrst_no_stale", a_rvalid, 0);
    end

    // Randomized traffic, backpressure, register churn and occasional resets
    for (int c = 0; c < 900; c++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 99) == 0);
      if (!arvalid || m_hs) begin
        arvalid = ($urandom_range(0, 3) != 0);
        araddr  = rand_addr();
        arprot  = 3'($urandom_range(0, 7));
      end
      rready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 1) == 0) regs32[$urandom_range(0, 15)] = $urandom;
      if ($urandom_range(0, 1) == 0) regs64[$urandom_range(0, 11)] = {$urandom, $urandom};
    end
    @(posedge clk); #1;
    rst = 1'b0; arvalid = 1'b0; rready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
